// File: rtl/cmd_sequencer.sv
// cmd_sequencer: assembles 3-byte host frames into wrapper commands and returns one result byte per info command.
// Optional macro CMD_SEQ_WRITE_ACK_EN: every write is acknowledged with response byte 8'hA0.
module cmd_sequencer #(
  parameter int unsigned      DATA_W  = 19,
  parameter int unsigned      RES_W   = 4,
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        opcode_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [1:0]        status_i,
  input  logic [RES_W-1:0]  result_i,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned RSV_LSB = DATA_W + 2;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_BAD    = 2'd3;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  localparam logic [7:0] RSP_BAD_FRAME = 8'hE1;
  localparam logic [7:0] RSP_TIMEOUT   = 8'hE0;
  localparam logic [7:0] RSP_IDLE      = 8'h50;
  localparam logic [3:0] RSP_RES_TAG   = 4'hA;
`ifdef CMD_SEQ_WRITE_ACK_EN
  localparam logic [7:0] RSP_WR_ACK    = 8'hA0;
`endif

  typedef enum logic [2:0] {
    S_COLLECT,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [1:0]           wb_cnt_q, wb_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [1:0]           opcode_d;
  logic [DATA_W-1:0]    data_d;
  logic [7:0]           tx_data_d;
  logic                 tx_valid_d;
  logic [7:0]           err_cnt_d;
  logic                 rx_ready_d;
  logic                 busy_d;

  logic [1:0]           frame_op;
  logic [DATA_W-1:0]    frame_data;
  logic                 rsv_bad;
  logic [7:0]           done_byte;
  logic [7:0]           err_inc;

  assign frame_op   = frame_q[DATA_W+1:DATA_W];
  assign frame_data = frame_q[DATA_W-1:0];
  assign rsv_bad    = (frame_q >> RSV_LSB) != '0;
  assign done_byte  = (status_i == ST_RESULT) ? {RSP_RES_TAG, 4'(result_i)} : RSP_IDLE;
  assign err_inc    = (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_COLLECT;
      byte_idx_q <= '0;
      frame_q    <= '0;
      wb_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      opcode_o   <= OP_NOP;
      data_o     <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err_cnt_o  <= '0;
      rx_ready   <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      wb_cnt_q   <= wb_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      opcode_o   <= opcode_d;
      data_o     <= data_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      err_cnt_o  <= err_cnt_d;
      rx_ready   <= rx_ready_d;
      busy_o     <= busy_d;
    end
  end

  // Next state; opcode_o/data_o default to idle so every command is a single-cycle pulse
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    wb_cnt_d   = wb_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    opcode_d   = OP_NOP;
    data_d     = '0;
    tx_data_d  = tx_data;
    err_cnt_d  = err_cnt_o;

    case (state_q)
      S_COLLECT: begin
        if (rx_valid && rx_ready) begin
          frame_d = {frame_q[FRAME_W-9:0], rx_data};
          if (byte_idx_q == 2'd2) begin
            byte_idx_d = '0;
            state_d    = S_DECODE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      S_DECODE: begin
        if (rsv_bad || frame_op == OP_BAD) begin
          err_cnt_d = err_inc;
          tx_data_d = RSP_BAD_FRAME;
          state_d   = S_RESP;
        end else if (frame_op == OP_NOP) begin
          state_d = S_COLLECT;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (frame_op == OP_WRITE) begin
          opcode_d = frame_op;
          data_d   = frame_data;
`ifdef CMD_SEQ_WRITE_ACK_EN
          tx_data_d = RSP_WR_ACK;
          state_d   = S_RESP;
`else
          state_d   = S_COLLECT;
`endif
        end else if (status_i != ST_BUSY) begin
          opcode_d = frame_op;
          data_d   = frame_data;
          wb_cnt_d = '0;
          state_d  = S_WAIT_BUSY;
        end
      end

      // wb_cnt 0 is the issue cycle itself; busy is looked for on counts 1 and 2
      S_WAIT_BUSY: begin
        wb_cnt_d = wb_cnt_q + 2'd1;
        if (wb_cnt_q != 2'd0) begin
          if (status_i == ST_BUSY) begin
            tmo_cnt_d = '0;
            state_d   = S_WAIT_DONE;
          end else if (wb_cnt_q == 2'd2) begin
            tx_data_d = done_byte;
            state_d   = S_RESP;
          end
        end
      end

      S_WAIT_DONE: begin
        if (status_i != ST_BUSY) begin
          tx_data_d = done_byte;
          state_d   = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_d == TMO_MAX) begin
            tx_data_d = RSP_TIMEOUT;
            err_cnt_d = err_inc;
            state_d   = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (tx_ready) begin
          state_d = S_COLLECT;
        end
      end

      default: state_d = S_COLLECT;
    endcase

    tx_valid_d = (state_d == S_RESP);
    rx_ready_d = (state_d == S_COLLECT);
    busy_d     = (state_d != S_COLLECT);
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: frame vector table plus hand sequences; commands and response bytes checked against queues.
module tb_cmd_sequencer;

  localparam int unsigned      DATA_W  = 19;
  localparam int unsigned      RES_W   = 4;
  localparam int unsigned      TMO_W   = 16;
  localparam logic [TMO_W-1:0] TMO_MAX = 16'd20;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [1:0]        opcode_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        status_i = 2'd0;
  logic [RES_W-1:0]  result_i;
  logic              busy_o;
  logic [7:0]        err_cnt_o;

  cmd_sequencer #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .TMO_W  (TMO_W),
    .TMO_MAX(TMO_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .opcode_o (opcode_o),
    .data_o   (data_o),
    .status_i (status_i),
    .result_i (result_i),
    .busy_o   (busy_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // kind: 0 = no-op frame, 1 = write, 2 = malformed
  typedef struct {
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        b2;
    int                kind;
    logic [DATA_W-1:0] data;
  } vec_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_tx[$];
  cmd_t       mc;
  int         errors  = 0;
  int         checks  = 0;
  int         exp_err = 0;

  // Wrapper model: wcnt counts cycles since the info issue cycle
  int         wcnt    = 100000;
  int         m_pre   = 0;
  int         m_busy  = 0;
  logic [1:0] m_final = 2'd0;
  logic       ovr_en  = 1'b0;
  logic [1:0] ovr_val = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (opcode_o == 2'd2) wcnt = 0;
    else if (wcnt < 100000) wcnt = wcnt + 1;
    if (ovr_en) status_i = ovr_val;
    else if (wcnt == 0 || wcnt > m_pre + m_busy) status_i = m_final;
    else if (wcnt <= m_pre) status_i = 2'd0;
    else status_i = 2'd1;
  end

  // Output monitor / scoreboard
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (opcode_o != 2'd0) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: actual op=%0d data=%0h required none", opcode_o, data_o);
        end else begin
          mc = exp_cmd.pop_front();
          check("cmd_op", opcode_o, mc.op);
          check("cmd_data", data_o, mc.data);
        end
      end
      if (pend) check("tx_valid_held", tx_valid, 1);
      if (tx_valid) begin
        check("rx_ready_in_resp", rx_ready, 0);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: actual tx_data=%0h required none", tx_data);
        end else begin
          check("tx_data", tx_data, exp_tx[0]);
          if (tx_ready) void'(exp_tx.pop_front());
        end
      end
      pend = tx_valid && !tx_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n    = 0;
    logic took = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!took && n < 500) begin
      took = rx_ready;
      step(1);
      n++;
    end
    rx_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout: byte %0h not taken after %0d cycles, required acceptance", b, n);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_tx.size() != 0) && n < 300) begin
      step(1);
      n++;
    end
    check("drain_done", (n < 300), 1);
    step(4);
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while (!tx_valid && n < 200) begin
      step(1);
      n++;
    end
    check({name, "_tx_seen"}, (n < 200), 1);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [DATA_W-1:0] d);
    cmd_t c;
    c.op   = op;
    c.data = d;
    exp_cmd.push_back(c);
`ifdef CMD_SEQ_WRITE_ACK_EN
    if (op == 2'd1) exp_tx.push_back(8'hA0);
`endif
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rx_ready"}, rx_ready, 1);
    check({name, "_tx_valid"}, tx_valid, 0);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_opcode"}, opcode_o, 0);
    check({name, "_data"}, data_o, 0);
    check({name, "_err_cnt"}, err_cnt_o, 0);
    check({name, "_busy"}, busy_o, 0);
  endtask

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{8'h00, 8'h00, 8'h05, 0, 19'h00000};
    vecs[1] = '{8'h08, 8'h12, 8'h34, 1, 19'h01234};
    vecs[2] = '{8'h0F, 8'hFF, 8'hFF, 1, 19'h7FFFF};
    vecs[3] = '{8'h18, 8'h00, 8'h00, 2, 19'h00000};
    vecs[4] = '{8'h80, 8'h00, 8'h00, 2, 19'h00000};
    vecs[5] = '{8'h20, 8'h00, 8'h00, 2, 19'h00000};
    vecs[6] = '{8'h00, 8'hFF, 8'hFF, 0, 19'h00000};
    vecs[7] = '{8'h0B, 8'h00, 8'h01, 1, 19'h30001};
    vecs[8] = '{8'h1C, 8'h00, 8'h00, 2, 19'h00000};

    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    result_i = '0;
    step(2);
    check_reset_vals("reset");
    rst = 1'b0;
    step(1);

    // Table: writes must issue even with the wrapper reporting busy
    ovr_en  = 1'b1;
    ovr_val = 2'd1;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].kind == 1) push_cmd(2'd1, vecs[i].data);
      if (vecs[i].kind == 2) begin
        exp_tx.push_back(8'hE1);
        exp_err++;
      end
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      drain();
      check("table_err_cnt", err_cnt_o, exp_err);
      check("table_idle_busy", busy_o, 0);
    end
    ovr_en = 1'b0;

    // Write latency: DECODE, ISSUE, then the one-cycle opcode pulse
    push_cmd(2'd1, 19'h2AAAA);
    send_frame(8'h0A, 8'hAA, 8'hAA);
    check("wr_lat_decode", opcode_o, 0);
    step(1);
    check("wr_lat_issue", opcode_o, 0);
    step(1);
    check("wr_lat_pulse", opcode_o, 1);
    check("wr_lat_data", data_o, 19'h2AAAA);
    step(1);
    check("wr_lat_end_op", opcode_o, 0);
    check("wr_lat_end_data", data_o, 0);
    drain();

    // Info with result 7, response back-pressured for 3 cycles
    m_pre    = 1;
    m_busy   = 5;
    m_final  = 2'd2;
    result_i = 4'd7;
    tx_ready = 1'b0;
    push_cmd(2'd2, 19'h00C03);
    exp_tx.push_back(8'hA7);
    send_frame(8'h10, 8'h0C, 8'h03);
    wait_tx("info_a7");
    check("info_a7_latency", wcnt, 7);
    step(3);
    check("info_a7_still_valid", tx_valid, 1);
    check("info_a7_rx_blocked", rx_ready, 0);
    tx_ready = 1'b1;
    step(1);
    check("info_a7_released", tx_valid, 0);
    check("info_a7_rx_back", rx_ready, 1);
    drain();

    // Info where the wrapper never goes busy
    m_pre   = 0;
    m_busy  = 0;
    m_final = 2'd0;
    push_cmd(2'd2, 19'h00000);
    exp_tx.push_back(8'h50);
    send_frame(8'h10, 8'h00, 8'h00);
    wait_tx("info_idle");
    check("info_idle_latency", wcnt, 2);
    drain();

    // Info held while busy, then timeout after TMO_MAX busy cycles
    ovr_en  = 1'b1;
    ovr_val = 2'd1;
    m_pre   = 0;
    m_busy  = 40;
    m_final = 2'd0;
    push_cmd(2'd2, 19'h00000);
    exp_tx.push_back(8'hE0);
    exp_err++;
    send_frame(8'h10, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("stall_no_issue", opcode_o, 0);
    end
    check("stall_busy", busy_o, 1);
    ovr_en = 1'b0;
    wait_tx("timeout");
    check("timeout_latency", wcnt, 21);
    drain();
    check("timeout_err_cnt", err_cnt_o, exp_err);

    // Reset mid-frame discards the partial bytes
    send_byte(8'h08);
    send_byte(8'h12);
    rst = 1'b1;
    step(1);
    check_reset_vals("rst_mid_frame");
    rst     = 1'b0;
    exp_err = 0;
    push_cmd(2'd1, 19'h01234);
    send_frame(8'h08, 8'h12, 8'h34);
    drain();

    // Reset during WAIT_DONE: no response byte afterwards
    m_pre   = 0;
    m_busy  = 40;
    m_final = 2'd0;
    push_cmd(2'd2, 19'h00C03);
    send_frame(8'h10, 8'h0C, 8'h03);
    n = 0;
    while ((exp_cmd.size() != 0 || wcnt < 5) && n < 100) begin
      step(1);
      n++;
    end
    check("wait_done_reached", (n < 100), 1);
    rst = 1'b1;
    step(1);
    check_reset_vals("rst_wait_done");
    rst = 1'b0;
    step(30);
    check("rst_wait_done_no_tx", tx_valid, 0);
    push_cmd(2'd1, 19'h2AAAA);
    send_frame(8'h0A, 8'hAA, 8'hAA);
    drain();
    check("post_rst_err_cnt", err_cnt_o, 0);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      exp_tx.push_back(8'hE1);
      if (exp_err < 255) exp_err++;
      send_frame(8'h80, 8'h00, 8'h00);
    end
    drain();
    check("err_cnt_saturated", err_cnt_o, exp_err);
    check("err_cnt_is_255", (exp_err == 255), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Host-side command front end that sits directly upstream of the inference wrapper.
- Assembles 3-byte frames from a byte stream (valid/ready) into {opcode, data} commands and drives the wrapper's opcode/data inputs for exactly one cycle per command.
- For info commands it tracks the wrapper status through busy to settled, captures the result and returns one response byte on a valid/ready byte output.
- Counts malformed frames.

Parameters:
- DATA_W, 19, wrapper data width; DATA_W+2 must be <= 24.
- RES_W, 4, wrapper result width; must be <= 4.
- TMO_W, 16, width of the completion-timeout counter.
- TMO_MAX, 16'hFFFF, cycles allowed in WAIT_DONE before a timeout response.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  frame byte, MSB-first
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  sequencer accepts a byte
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  consumer accepts the response
- opcode_o  out  2  to wrapper: 0 idle, 1 write, 2 info
- data_o  out  DATA_W  to wrapper data input
- status_i  in  2  from wrapper: 0 idle, 1 busy, 2 idle with result
- result_i  in  RES_W  from wrapper result
- busy_o  out  1  high in any state other than COLLECT
- err_cnt_o  out  8  count of bad frames, saturates at 255

Behaviour:
- Reset (rst sampled high at clk): state=COLLECT, byte index=0, opcode_o=0, data_o=0, tx_valid=0, tx_data=0, err_cnt_o=0, timeout counter=0. Reset mid-frame or mid-wait discards all progress; no response byte is emitted.
- Byte handshake: a byte transfers when rx_valid&&rx_ready. rx_ready=1 only in COLLECT. A response byte transfers when tx_valid&&tx_ready. tx_valid, once raised, holds with tx_data stable until accepted.
- Frame: 24-bit word W = {byte0, byte1, byte2}. Opcode = W[DATA_W+1:DATA_W], data = W[DATA_W-1:0]. Bits above DATA_W+1 are reserved and must be 0.
- COLLECT: shift accepted bytes in. On the 3rd byte, go to DECODE.
- DECODE (1 cycle):
  - Reserved bits nonzero or opcode==3: err_cnt++ (saturating), tx_data=8'hE1, go to RESP.
  - opcode 0: go to COLLECT; nothing is driven.
  - opcode 1: go to ISSUE.
  - opcode 2: go to ISSUE.
- ISSUE, write: opcode_o=1 and data_o=data for exactly 1 cycle, then opcode_o=0 and data_o=0, then go to COLLECT. A write is issued regardless of status_i.
- ISSUE, info: if status_i==1, hold with opcode_o=0 until status_i!=1. Then drive opcode_o=2 and data_o for exactly 1 cycle and go to WAIT_BUSY.
- WAIT_BUSY:
  - status_i==1 on either of the 2 cycles after the issue cycle: go to WAIT_DONE and clear the timeout counter.
  - status_i never busy in that window (zero-length count): sample as in WAIT_DONE completion on the 2nd cycle.
- WAIT_DONE:
  - On the first cycle with status_i!=1, load tx_data: if status_i==2, {4'hA, result_i zero-extended}; if status_i==0, 8'h50. Go to RESP.
  - Timeout counter increments each cycle. On reaching TMO_MAX: tx_data=8'hE0, err_cnt++, go to RESP.
- RESP: tx_valid=1. On acceptance, tx_valid=0 and go to COLLECT.
- Simultaneous events: rst has priority over everything. A byte offered while not in COLLECT stalls (not dropped). err_cnt_o holds at 255.
- Latency: last rx byte accepted at edge N, then DECODE at N+1, then opcode_o asserted during cycle N+2 (no busy stall).

Optional Feature:
- Macro CMD_SEQ_WRITE_ACK_EN.
- Defined: after a write ISSUE, go to RESP with tx_data=8'hA0 instead of COLLECT, so every write is acknowledged.
- Undefined: writes produce no response; rx_ready returns the cycle after ISSUE.

Test Plan:
- Bytes 00,00,05 then 08,12,34 -> nothing driven for the opcode-0 frame; opcode_o=1 for exactly one cycle with data_o=19'h01234; no tx byte (macro off).
- Info frame 10,0C,03 with model status 0,1×5,2 and result 7 -> opcode_o=2 once, data_o=19'h00C03; tx_data=8'hA7; held across tx_ready low for 3 cycles; rx_ready=0 until accepted.
- Info frame 10,00,00 with status staying 0 -> tx_data=8'h50 two cycles after issue.
- Frame 18,00,00 (opcode 3) and frame 80,00,00 (reserved bit) -> two 8'hE1 responses; err_cnt_o=2; opcode_o never asserted.
- Info with status stuck at 1, TMO_MAX=20 -> 8'hE0 after 20 WAIT_DONE cycles; info issued while status_i=1 is held until status_i drops.
- rst pulsed after 2 bytes and again during WAIT_DONE -> all outputs at reset values, no tx byte; the next full frame is decoded correctly. With CMD_SEQ_WRITE_ACK_EN, a write frame -> 8'hA0.
